// File: rtl/muldiv_unit.sv
// muldiv_unit -- multi-cycle RV32M multiply/divide execution unit.
//
// Radix-2 iterative datapath: a 32-step shift-add multiplier and a 32-step
// restoring divider share one 65-bit accumulator. Divide-by-zero and the
// signed overflow case (0x80000000 / -1) bypass the iteration and complete
// one cycle after the request. busy_o stalls EX until the done_o pulse.
//
// Ports:
//   clk_i      clock, rising edge
//   reset_i    asynchronous active-low reset
//   start_i    request strobe, sampled only while idle
//   sel_i      0 = multiply, 1 = divide
//   op_mul_i   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   op_div_i   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_i      operand A / dividend, sampled with start_i
//   rs2_i      operand B / divisor, sampled with start_i
//   kill_i     abort the current operation (flush / trap)
//   busy_o     operation in progress
//   done_o     one-cycle pulse, result_o valid
//   result_o   result, held until the next completed operation
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            sel_i,
    input  logic [1:0]      op_mul_i,
    input  logic [1:0]      op_div_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sel_q;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [XLEN:0]     b_mag_q;
    // Multiply: {carry/high half, low half}; low half starts as |A|.
    // Divide:   {remainder (33b), dividend shifting out / quotient shifting in}.
    logic [2*XLEN:0]   acc_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Magnitude of a possibly negative operand, widened so |0x80000000| fits.
    function automatic logic [XLEN:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        magnitude = neg ? ({1'b0, ~v} + (XLEN+1)'(1)) : {1'b0, v};
    endfunction

    // Request decode, only meaningful in the cycle start_i is accepted.
    logic            a_signed_d, b_signed_d, a_neg_d, b_neg_d, neg_d;
    logic [XLEN:0]   a_mag_d, b_mag_d;
    logic            fast_d;
    logic [XLEN-1:0] fast_res_d;

    always_comb begin
        a_signed_d = sel_i ? ~op_div_i[0] : (op_mul_i != 2'b11);
        b_signed_d = sel_i ? ~op_div_i[0] : ~op_mul_i[1];
        a_neg_d    = a_signed_d & rs1_i[XLEN-1];
        b_neg_d    = b_signed_d & rs2_i[XLEN-1];
        a_mag_d    = magnitude(rs1_i, a_neg_d);
        b_mag_d    = magnitude(rs2_i, b_neg_d);
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_d      = (sel_i && op_div_i[1]) ? a_neg_d : (a_neg_d ^ b_neg_d);

        fast_d     = 1'b0;
        fast_res_d = '0;
        if (sel_i) begin
            if (rs2_i == '0) begin
                fast_d     = 1'b1;
                fast_res_d = op_div_i[1] ? rs1_i : '1;
            end else if (~op_div_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                         && (rs2_i == '1)) begin
                fast_d     = 1'b1;
                fast_res_d = op_div_i[1] ? '0 : rs1_i;
            end
        end
    end

    // One iteration of the selected algorithm.
    logic [XLEN:0]   mul_sum_d;
    logic [XLEN:0]   div_shift_d;
    logic [XLEN+1:0] div_diff_d;
    logic            div_ok_d;
    logic [2*XLEN:0] acc_d;

    always_comb begin
        mul_sum_d   = acc_q[2*XLEN:XLEN] + (acc_q[0] ? b_mag_q : '0);
        div_shift_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff_d  = {1'b0, div_shift_d} - {1'b0, b_mag_q};
        div_ok_d    = ~div_diff_d[XLEN+1];   // no borrow: divisor fits
        if (sel_q) begin
            acc_d = {(div_ok_d ? div_diff_d[XLEN:0] : div_shift_d),
                     acc_q[XLEN-2:0], div_ok_d};
        end else begin
            acc_d = {1'b0, mul_sum_d, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection.
    logic [2*XLEN-1:0] prod_fix_d;
    logic [XLEN-1:0]   quo_fix_d, rem_fix_d, fix_res_d;

    always_comb begin
        prod_fix_d = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
        quo_fix_d  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix_d  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (sel_q) begin
            fix_res_d = op_q[1] ? rem_fix_d : quo_fix_d;
        end else begin
            fix_res_d = (op_q == 2'b00) ? prod_fix_d[XLEN-1:0]
                                        : prod_fix_d[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        sel_q   <= sel_i;
                        op_q    <= sel_i ? op_div_i : op_mul_i;
                        neg_q   <= neg_d;
                        b_mag_q <= b_mag_d;
                        acc_q   <= {{XLEN{1'b0}}, a_mag_d};
                        cnt_q   <= CNT_W'(XLEN-1);
                        if (fast_d) begin
                            result_q <= fast_res_d;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_res_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
